// File: rtl/dm_arb_if.sv
// Requester-side bundle of the dat_mem arbiter: per-requester request,
// burst lock, write enable, packed address/write data, plus the grant,
// read-valid and shared read data returned by the arbiter.
interface dm_arb_if #(
    parameter int NREQ = 3,
    parameter int AW   = 8,
    parameter int DW   = 8
) ();
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    lock;
    logic [NREQ-1:0]    we;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvalid;
    logic [DW-1:0]      rdata;

    // Requesters drive the request side and observe grant/read return.
    modport master (
        output req, lock, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    // The arbiter consumes requests and produces grant/read return.
    modport slave (
        input  req, lock, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dm_arb.sv
// Round-robin arbiter and access sequencer for the single dat_mem port.
// One requester is granted per cycle (combinational grant); its address,
// write enable and write data are steered onto the memory. A granted read
// returns rvalid one cycle later alongside the memory's registered data.
// A requester holding lock keeps the port for at most MAX_LOCK owned cycles.
module dm_arb #(
    parameter int NREQ     = 3,
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int MAX_LOCK = 64
) (
    input  logic          clk,
    input  logic          init_n,
    dm_arb_if.slave       bus,
    output logic [AW-1:0] mem_raddr,
    output logic [AW-1:0] mem_waddr,
    output logic          mem_wr_en,
    output logic [DW-1:0] mem_data_in,
    input  logic [DW-1:0] mem_data_out
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_LOCK + 1);

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [CW-1:0]   lock_cnt_q, lock_cnt_d;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] rvalid_p1;
    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   cand;

    // Index base+k reduced modulo NREQ; base < NREQ and k <= NREQ, so a
    // single conditional subtract is enough and non-power-of-two NREQ wraps.
    function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return s[PW-1:0];
    endfunction

    // Round-robin search starting just after the last winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = rr_index(ptr_q, k);
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state and grant logic. lock_cnt counts owned cycles already
    // completed (the ARB cycle that took the lock is the first), so the
    // current locked cycle is number lock_cnt+1 and the burst ends once it
    // reaches MAX_LOCK. Idle cycles inside a lock still count.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        gnt        = '0;
        case (state_q)
            ARB: begin
                if (win_found) begin
                    gnt[win_idx] = 1'b1;
                    ptr_d        = win_idx;
                    if (bus.lock[win_idx] && (MAX_LOCK > 1)) begin
                        state_d    = LOCKED;
                        owner_d    = win_idx;
                        lock_cnt_d = CW'(1);
                    end
                end
            end
            LOCKED: begin
                gnt[owner_q] = bus.req[owner_q];
                if (!bus.lock[owner_q] || (lock_cnt_q == CW'(MAX_LOCK - 1))) begin
                    state_d    = ARB;
                    ptr_d      = owner_q;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ARB;
            end
        endcase
        // No access may be issued while reset is held.
        if (!init_n) gnt = '0;
    end

    // Steer the granted requester's access onto the memory port.
    always_comb begin
        mem_raddr   = '0;
        mem_wr_en   = 1'b0;
        mem_data_in = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                mem_raddr   = bus.addr[i*AW +: AW];
                mem_wr_en   = bus.we[i];
                mem_data_in = bus.wdata[i*DW +: DW];
            end
        end
    end

    assign mem_waddr  = mem_raddr;
    assign bus.gnt    = gnt;
    assign bus.rvalid = rvalid_p1;
    assign bus.rdata  = mem_data_out;

    // FSM state, round-robin pointer, lock owner/count and read-return flag.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_q    <= ARB;
            ptr_q      <= PW'(NREQ - 1);
            owner_q    <= '0;
            lock_cnt_q <= '0;
            rvalid_p1  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
            // stage p0 -> p1: granted reads see their data next cycle
            rvalid_p1  <= gnt & ~bus.we;
        end
    end
endmodule

// File: doc/dm_arb.md
# dm_arb

Round-robin arbiter and access sequencer sharing the single 8-bit-wide `dat_mem` port among several requesters, such as a host loader, the LFSR decrypt engine and a checker. Each cycle it grants at most one requester and steers that requester's address, write enable and write data onto the memory. It returns the memory's registered read data to the requester one cycle later. A lock mechanism lets one requester hold the port for a bounded burst, for example a 64-byte decrypted-message write.

## Interface
- NREQ, 3, number of requesters (2..8)
- AW, 8, memory address width
- DW, 8, memory data width
- MAX_LOCK, 64, maximum consecutive locked cycles per ownership

- clk  in  1  single clock, all state on rising edge
- init_n  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester access request
- lock  in  NREQ  per-requester burst-hold request, sampled only with req
- we  in  NREQ  per-requester write (1) / read (0)
- addr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
- wdata  in  NREQ*DW  packed write data, requester i at [i*DW +: DW]
- gnt  out  NREQ  one-hot grant, combinational, access issued this cycle
- rvalid  out  NREQ  one-hot, registered, read data valid for requester i
- rdata  out  DW  equals mem_data_out, meaningful only when rvalid is set
- mem_raddr  out  AW  to dat_mem raddr
- mem_waddr  out  AW  to dat_mem waddr, same value as mem_raddr
- mem_wr_en  out  1  to dat_mem write_en
- mem_data_in  out  DW  to dat_mem data_in
- mem_data_out  in  DW  from dat_mem, registered read with 1-cycle latency

## Operation
- State machine has two states, ARB and LOCKED, plus the registers ptr (last winner), owner and lock_cnt.
- ARB:
  - Winner is the first requester with req=1, searching ptr+1, ptr+2, … modulo NREQ.
  - gnt is set for the winner; ptr takes the winner's index at the clock edge.
  - If the winner also has lock=1: next state is LOCKED, owner takes the winner, lock_cnt=1.
- LOCKED:
  - Only owner can be granted. gnt[owner]=req[owner]; all others get 0.
  - If req[owner]=0 while lock[owner]=1, the bus idles. The cycle still counts toward lock_cnt.
  - Return to ARB when lock[owner]=0 or lock_cnt==MAX_LOCK.
  - On that transition ptr takes owner, so the former owner has lowest priority next.
  - Otherwise lock_cnt increments.
  - The cycle with lock[owner]=0 is still a granted cycle if req[owner]=1.
- Memory steering:
  - When gnt[i]=1: mem_raddr = mem_waddr = addr[i], mem_data_in = wdata[i], mem_wr_en = we[i].
  - When no grant: mem_wr_en=0, addresses and data are 0.
- Read return: a granted read (we=0) by i sets rvalid[i] in the next cycle only. Writes never set rvalid.
- Arithmetic and widths:
  - ptr is clog2(NREQ) bits and wraps modulo NREQ (not 2^width).
  - lock_cnt is clog2(MAX_LOCK+1) bits and never exceeds MAX_LOCK.
- Read-after-write to the same address in back-to-back grants returns the new data, per dat_mem write-then-read behaviour. The arbiter adds no forwarding.

## Timing
- Reset (init_n low, any time):
  - State goes to ARB; ptr=NREQ-1, so requester 0 has first priority; owner=0; lock_cnt=0.
  - rvalid=0. gnt=0 and mem_wr_en=0 are forced combinationally while init_n is low.
- Reset mid-burst aborts the lock. A read granted in the cycle before reset asserts yields no rvalid.
- Grant latency is 0 cycles, since gnt is combinational from req. Read data latency is 1 cycle after gnt.
- A requester must hold req, we, addr and wdata stable while waiting; dropping req before gnt withdraws the request.
- Throughput is one access per cycle with no bubbles between different winners.

## Test plan
- Reset with req=3'b111 and lock=0, then 6 cycles: gnt sequence 001, 010, 100, 001, 010, 100; mem_wr_en follows we of the winner.
- Requester 1 writes 8'hA5 to addr 8'h40, then reads 8'h40 next cycle: mem_wr_en=1 in cycle 0; rvalid=3'b010 with rdata=8'hA5 in cycle 2.
- MAX_LOCK=4, req=3'b111, lock=3'b001 held: gnt=001 for exactly 4 cycles, then 010; requester 0 next wins only after 010 and 100.
- Requester 2 locks, drops req for 2 cycles with lock high: gnt=000 during the gap, other requests are blocked, and the gap cycles count toward MAX_LOCK.
- Drop lock[0] after 3 locked cycles with req=3'b101: that cycle grants 001, and the next cycle grants 100.
- Assert init_n=0 during a locked burst after a read grant: gnt and rvalid go to 0 immediately. After release, req=3'b110 grants 010 first.
